// File: rtl/fust_scalar_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fust_scalar_scoreboard_pkg
// Brief    : Types and constants shared by the scalar FU status scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
package fust_scalar_scoreboard_pkg;

    localparam int NUM_FU        = 3;
    localparam int NUM_REGS      = 32;
    localparam int REG_W         = 5;
    localparam int FU_S_W        = 2;
    localparam int NUM_SCALAR_FU = NUM_FU;

    typedef logic [REG_W-1:0]  regbits_t;
    typedef logic [FU_S_W-1:0] fu_sbits_t;

    typedef enum logic [FU_S_W-1:0] {
        FU_ALU    = 2'd0,
        FU_LD_ST  = 2'd1,
        FU_BRANCH = 2'd2,
        FU_NONE   = 2'd3
    } fu_scalar_e;

    typedef struct packed {
        logic      busy;
        regbits_t  r;
        regbits_t  r1;
        regbits_t  r2;
        fu_sbits_t t1;
        fu_sbits_t t2;
        logic      rdy1;
        logic      rdy2;
        logic      issued;
    } fust_s_row_t;

    typedef fust_s_row_t [NUM_FU-1:0] fust_s_t;

    typedef struct packed {
        logic      valid;
        fu_sbits_t fu;
    } rstat_entry_t;

    localparam fust_s_row_t c_ROW_IDLE = '{
        busy: 1'b0, r: '0, r1: '0, r2: '0, t1: '0, t2: '0,
        rdy1: 1'b1, rdy2: 1'b1, issued: 1'b0
    };

    localparam fu_sbits_t c_FU_LIMIT = fu_sbits_t'(NUM_FU);

    function automatic logic fu_in_range(input fu_sbits_t fu);
        return fu < c_FU_LIMIT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fust_scalar_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : fust_scalar_scoreboard_if
// Brief    : Dispatch / issue / writeback bundle of the scalar scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
interface fust_scalar_scoreboard_if;
    import fust_scalar_scoreboard_pkg::*;

    logic              disp_valid;
    fu_sbits_t         disp_fu;
    regbits_t          disp_rd;
    regbits_t          disp_rs1;
    regbits_t          disp_rs2;
    logic              disp_wen;
    logic              disp_ready;
    logic [NUM_FU-1:0] issue_ready;
    logic [NUM_FU-1:0] issue_ack;
    fust_s_t           fust;
    logic              wb_valid;
    fu_sbits_t         wb_fu;

    modport master (
        output disp_valid, disp_fu, disp_rd, disp_rs1, disp_rs2, disp_wen,
        output issue_ack, wb_valid, wb_fu,
        input  disp_ready, issue_ready, fust
    );

    modport slave (
        input  disp_valid, disp_fu, disp_rd, disp_rs1, disp_rs2, disp_wen,
        input  issue_ack, wb_valid, wb_fu,
        output disp_ready, issue_ready, fust
    );

endinterface
`default_nettype wire

// File: rtl/fust_scalar_scoreboard_reg_result_status.sv
`default_nettype none
// ============================================================================
// Module   : fust_scalar_scoreboard_reg_result_status
// Brief    : Register result-status table: which FU will write each register.
// Revision : 1.0 - initial release
// ============================================================================
module fust_scalar_scoreboard_reg_result_status
    import fust_scalar_scoreboard_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_alloc_en,
    input  regbits_t     i_alloc_rd,
    input  fu_sbits_t    i_alloc_fu,
    input  logic         i_clr_en,
    input  regbits_t     i_clr_rd,
    input  fu_sbits_t    i_clr_fu,
    input  regbits_t     i_look_rs1,
    input  regbits_t     i_look_rs2,
    input  regbits_t     i_look_rd,
    output rstat_entry_t o_ent_rs1,
    output rstat_entry_t o_ent_rs2,
    output rstat_entry_t o_ent_rd
);

    rstat_entry_t r_table [NUM_REGS];

    // Allocation is written last so a new producer overrides the clear of
    // its predecessor when both target the same register in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_table[i] <= '0;
            end
        end else begin
            if (i_clr_en && r_table[i_clr_rd].valid && r_table[i_clr_rd].fu == i_clr_fu) begin
                r_table[i_clr_rd] <= '0;
            end
            if (i_alloc_en && i_alloc_rd != '0) begin
                r_table[i_alloc_rd] <= '{valid: 1'b1, fu: i_alloc_fu};
            end
        end
    end

    assign o_ent_rs1 = r_table[i_look_rs1];
    assign o_ent_rs2 = r_table[i_look_rs2];
    assign o_ent_rd  = r_table[i_look_rd];

endmodule
`default_nettype wire

// File: rtl/fust_scalar_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : fust_scalar_scoreboard
// Brief    : Scalar FU status scoreboard between dispatch and issue.
//            Optional macro FUST_WB_BYPASS_EN lets a same-cycle writeback
//            free rows, clear WAW hazards and satisfy captured operands.
// Revision : 1.0 - initial release
// ============================================================================
module fust_scalar_scoreboard
    import fust_scalar_scoreboard_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    fust_scalar_scoreboard_if.slave bus
);

    fust_s_t           w_fust;
    logic [NUM_FU-1:0] w_issue_ready;
    rstat_entry_t      w_ent_rs1;
    rstat_entry_t      w_ent_rs2;
    rstat_entry_t      w_ent_rd;
    fust_s_row_t       w_new_row;
    regbits_t          w_wb_rd;
    logic              w_wb_hit;
    logic              w_disp_busy;
    logic              w_row_free;
    logic              w_waw_clr;
    logic              w_src1_clr;
    logic              w_src2_clr;
    logic              w_waw;
    logic              w_dep1;
    logic              w_dep2;
    logic              w_disp_ready;
    logic              w_accept;
    logic              w_alloc_en;

    // A writeback only counts when it targets a busy row.
    always_comb begin
        w_wb_hit    = 1'b0;
        w_wb_rd     = '0;
        w_disp_busy = 1'b0;
        for (int f = 0; f < NUM_FU; f++) begin
            if (bus.wb_fu == fu_sbits_t'(f) && w_fust[f].busy) begin
                w_wb_hit = bus.wb_valid;
                w_wb_rd  = w_fust[f].r;
            end
            if (bus.disp_fu == fu_sbits_t'(f)) begin
                w_disp_busy = w_fust[f].busy;
            end
        end
    end

`ifdef FUST_WB_BYPASS_EN
    assign w_row_free = !w_disp_busy || (w_wb_hit && bus.wb_fu == bus.disp_fu);
    assign w_waw_clr  = w_wb_hit && w_ent_rd.fu  == bus.wb_fu;
    assign w_src1_clr = w_wb_hit && w_ent_rs1.fu == bus.wb_fu;
    assign w_src2_clr = w_wb_hit && w_ent_rs2.fu == bus.wb_fu;
`else
    assign w_row_free = !w_disp_busy;
    assign w_waw_clr  = 1'b0;
    assign w_src1_clr = 1'b0;
    assign w_src2_clr = 1'b0;

    // Writeback seen last cycle: wakes operands captured during that cycle.
    logic      r_late_hit;
    fu_sbits_t r_late_fu;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_late_hit <= 1'b0;
            r_late_fu  <= '0;
        end else begin
            r_late_hit <= w_wb_hit;
            r_late_fu  <= bus.wb_fu;
        end
    end
`endif

    assign w_waw        = bus.disp_wen && bus.disp_rd != '0 && w_ent_rd.valid && !w_waw_clr;
    assign w_dep1       = bus.disp_rs1 != '0 && w_ent_rs1.valid && !w_src1_clr;
    assign w_dep2       = bus.disp_rs2 != '0 && w_ent_rs2.valid && !w_src2_clr;
    assign w_disp_ready = fu_in_range(bus.disp_fu) && w_row_free && !w_waw;
    assign w_accept     = bus.disp_valid && w_disp_ready;
    assign w_alloc_en   = w_accept && bus.disp_wen && bus.disp_rd != '0;

    always_comb begin
        w_new_row        = c_ROW_IDLE;
        w_new_row.busy   = 1'b1;
        w_new_row.r      = bus.disp_rd;
        w_new_row.r1     = bus.disp_rs1;
        w_new_row.r2     = bus.disp_rs2;
        w_new_row.t1     = w_dep1 ? w_ent_rs1.fu : '0;
        w_new_row.t2     = w_dep2 ? w_ent_rs2.fu : '0;
        w_new_row.rdy1   = !w_dep1;
        w_new_row.rdy2   = !w_dep2;
    end

    for (genvar f = 0; f < NUM_FU; f++) begin : g_row
        localparam fu_sbits_t c_TAG = fu_sbits_t'(f);

        fust_s_row_t r_row;
        fust_s_row_t w_nxt;
        logic        w_ready;

        assign w_ready = r_row.busy && !r_row.issued && r_row.rdy1 && r_row.rdy2;

        // Priority: ack, wake-ups, then writeback clear, then new capture.
        always_comb begin
            w_nxt = r_row;
            if (bus.issue_ack[f] && w_ready) begin
                w_nxt.issued = 1'b1;
            end
            if (r_row.busy) begin
                if (!r_row.rdy1 && w_wb_hit && r_row.t1 == bus.wb_fu) w_nxt.rdy1 = 1'b1;
                if (!r_row.rdy2 && w_wb_hit && r_row.t2 == bus.wb_fu) w_nxt.rdy2 = 1'b1;
`ifndef FUST_WB_BYPASS_EN
                if (!r_row.rdy1 && r_late_hit && r_row.t1 == r_late_fu) w_nxt.rdy1 = 1'b1;
                if (!r_row.rdy2 && r_late_hit && r_row.t2 == r_late_fu) w_nxt.rdy2 = 1'b1;
`endif
            end
            if (w_wb_hit && bus.wb_fu == c_TAG) begin
                w_nxt = c_ROW_IDLE;
            end
            if (w_accept && bus.disp_fu == c_TAG) begin
                w_nxt = w_new_row;
            end
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                r_row <= c_ROW_IDLE;
            end else begin
                r_row <= w_nxt;
            end
        end

        assign w_fust[f]        = r_row;
        assign w_issue_ready[f] = w_ready;
    end

    fust_scalar_scoreboard_reg_result_status u_rstat (
        .clk        (CLK),
        .rst        (RST),
        .i_alloc_en (w_alloc_en),
        .i_alloc_rd (bus.disp_rd),
        .i_alloc_fu (bus.disp_fu),
        .i_clr_en   (w_wb_hit),
        .i_clr_rd   (w_wb_rd),
        .i_clr_fu   (bus.wb_fu),
        .i_look_rs1 (bus.disp_rs1),
        .i_look_rs2 (bus.disp_rs2),
        .i_look_rd  (bus.disp_rd),
        .o_ent_rs1  (w_ent_rs1),
        .o_ent_rs2  (w_ent_rs2),
        .o_ent_rd   (w_ent_rd)
    );

    assign bus.disp_ready  = w_disp_ready;
    assign bus.issue_ready = w_issue_ready;
    assign bus.fust        = w_fust;

endmodule
`default_nettype wire
